// File: rtl/bcd_to_bin_seq.sv
// Sequential BCD-to-binary converter: one digit per clock, MSD first,
// acc = acc*10 + digit, with sticky invalid-digit / overflow error.
module bcd_to_bin_seq #(
  parameter int DIGITS = 3,
  parameter int OUT_W  = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [4*DIGITS-1:0]   bcd_in,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic [OUT_W-1:0]      bin_out
);

  localparam int ACC_W = OUT_W + 4;
  localparam int CNT_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DIGITS - 1);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    CONV = 1'b1
  } state_t;

  // acc*10 + digit built from shifts; the four guard bits keep it from wrapping
  function automatic logic [ACC_W-1:0] mul10_add(input logic [ACC_W-1:0] acc,
                                                 input logic [3:0]       digit);
    mul10_add = (acc << 3'd3) + (acc << 3'd1) + {{OUT_W{1'b0}}, digit};
  endfunction

  function automatic logic digit_invalid(input logic [3:0] digit);
    digit_invalid = (digit > 4'd9);
  endfunction

  state_t                state_r, state_s;
  logic [4*DIGITS-1:0]   shift_r, shift_s;
  logic [ACC_W-1:0]      acc_r, acc_s;
  logic [CNT_W-1:0]      cnt_r, cnt_s;
  logic                  sticky_r, sticky_s;
  logic [OUT_W-1:0]      bin_r, bin_s;
  logic                  err_r, err_s;
  logic                  done_r, done_s;

  logic [3:0]            digit_s;
  logic [ACC_W-1:0]      next_s;
  logic                  bad_digit_s;
  logic                  ovf_s;

  // Datapath for the digit currently at the top of the shift register
  always_comb begin
    digit_s     = shift_r[4*DIGITS-1 -: 4];
    next_s      = mul10_add(acc_r, digit_s);
    bad_digit_s = digit_invalid(digit_s);
    ovf_s       = (next_s[ACC_W-1:OUT_W] != 4'd0);
  end

  // Next-state and next-register logic
  always_comb begin
    state_s  = state_r;
    shift_s  = shift_r;
    acc_s    = acc_r;
    cnt_s    = cnt_r;
    sticky_s = sticky_r;
    bin_s    = bin_r;
    err_s    = err_r;
    done_s   = 1'b0;
    case (state_r)
      IDLE: begin
        if (start) begin
          shift_s  = bcd_in;
          acc_s    = '0;
          sticky_s = 1'b0;
          cnt_s    = LAST_CNT;
          state_s  = CONV;
        end else begin
          state_s  = IDLE;
        end
      end
      CONV: begin
        shift_s  = shift_r << 3'd4;
        acc_s    = next_s;
        sticky_s = sticky_r | bad_digit_s | ovf_s;
        if (cnt_r == '0) begin
          cnt_s   = '0;
          bin_s   = sticky_s ? {OUT_W{1'b1}} : next_s[OUT_W-1:0];
          err_s   = sticky_s;
          done_s  = 1'b1;
          state_s = IDLE;
        end else begin
          cnt_s   = cnt_r - CNT_W'(1);
          state_s = CONV;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r  <= IDLE;
      shift_r  <= '0;
      acc_r    <= '0;
      cnt_r    <= '0;
      sticky_r <= 1'b0;
      bin_r    <= '0;
      err_r    <= 1'b0;
      done_r   <= 1'b0;
    end else begin
      state_r  <= state_s;
      shift_r  <= shift_s;
      acc_r    <= acc_s;
      cnt_r    <= cnt_s;
      sticky_r <= sticky_s;
      bin_r    <= bin_s;
      err_r    <= err_s;
      done_r   <= done_s;
    end
  end

  assign busy    = (state_r == CONV);
  assign done    = done_r;
  assign err     = err_r;
  assign bin_out = bin_r;

endmodule
